// File: rtl/simon_decrypt_iter_if.sv
// Start/busy/done request bus for the iterative Simon 32/64 decryptor.
// The master issues key and ciphertext; the slave returns the plaintext.
interface simon_decrypt_iter_if;
   logic        start;
   logic [63:0] keytext;
   logic [31:0] ciphertext;
   logic [31:0] plaintext;
   logic        busy;
   logic        done;

   modport master (
      output start, keytext, ciphertext,
      input  plaintext, busy, done
   );

   modport slave (
      input  start, keytext, ciphertext,
      output plaintext, busy, done
   );
endinterface

// File: rtl/simon_decrypt_iter.sv
// Iterative Simon 32/64 decryptor, one round per clock: 28 forward key-schedule steps, then
// 32 decryption rounds that unroll the key schedule backward. Start-to-done latency 60 clocks.
module simon_decrypt_iter (
   input  logic                   clk,
   input  logic                   rst,
   simon_decrypt_iter_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXPAND  = 2'd1,
      S_DECRYPT = 2'd2
   } state_t;

   // z0 with its leftmost character in bit 61, so z0[i] lives at bit 61-i.
   localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
   localparam logic [15:0] KEY_C = 16'hFFFC;

   function automatic logic [15:0] rol1(input logic [15:0] v);
      return {v[14:0], v[15]};
   endfunction

   function automatic logic [15:0] rol2(input logic [15:0] v);
      return {v[13:0], v[15:14]};
   endfunction

   function automatic logic [15:0] rol8(input logic [15:0] v);
      return {v[7:0], v[15:8]};
   endfunction

   function automatic logic [15:0] ror1(input logic [15:0] v);
      return {v[0], v[15:1]};
   endfunction

   function automatic logic [15:0] ror3(input logic [15:0] v);
      return {v[2:0], v[15:3]};
   endfunction

   function automatic logic [15:0] round_f(input logic [15:0] v);
      return (rol1(v) & rol8(v)) ^ rol2(v);
   endfunction

   state_t      r_state;
   logic [4:0]  r_cnt;
   logic [15:0] r_w3, r_w2, r_w1, r_w0;
   logic [15:0] r_x, r_y;
   logic [31:0] r_pt;
   logic        r_busy;
   logic        r_done;

   logic [4:0]  w_inv_idx;
   logic        w_z_fwd;
   logic        w_z_inv;
   logic [15:0] w_fwd_tmp;
   logic [15:0] w_fwd_k;
   logic [15:0] w_inv_tmp;
   logic [15:0] w_inv_k;
   logic [15:0] w_x_nxt;
   logic [15:0] w_y_nxt;

   // Forward step produces k[cnt+4]; inverse step recovers k[r-4] from k[r], k[r-1], k[r-3].
   assign w_inv_idx = r_cnt - 5'd4;
   assign w_z_fwd   = Z0[6'd61 - {1'b0, r_cnt}];
   assign w_z_inv   = Z0[6'd61 - {1'b0, w_inv_idx}];

   assign w_fwd_tmp = ror3(r_w3) ^ r_w1;
   assign w_fwd_k   = r_w0 ^ w_fwd_tmp ^ ror1(w_fwd_tmp) ^ KEY_C ^ {15'd0, w_z_fwd};

   assign w_inv_tmp = ror3(r_w2) ^ r_w0;
   assign w_inv_k   = r_w3 ^ w_inv_tmp ^ ror1(w_inv_tmp) ^ KEY_C ^ {15'd0, w_z_inv};

   assign w_x_nxt   = r_y;
   assign w_y_nxt   = r_x ^ round_f(r_y) ^ r_w3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 5'd0;
         r_w3    <= 16'd0;
         r_w2    <= 16'd0;
         r_w1    <= 16'd0;
         r_w0    <= 16'd0;
         r_x     <= 16'd0;
         r_y     <= 16'd0;
         r_pt    <= 32'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_w3    <= bus.keytext[63:48];
                  r_w2    <= bus.keytext[47:32];
                  r_w1    <= bus.keytext[31:16];
                  r_w0    <= bus.keytext[15:0];
                  r_x     <= bus.ciphertext[31:16];
                  r_y     <= bus.ciphertext[15:0];
                  r_cnt   <= 5'd0;
                  r_busy  <= 1'b1;
                  r_state <= S_EXPAND;
               end
            end

            S_EXPAND: begin
               r_w0 <= r_w1;
               r_w1 <= r_w2;
               r_w2 <= r_w3;
               r_w3 <= w_fwd_k;
               // After 28 steps the window holds {k31, k30, k29, k28}.
               if (r_cnt == 5'd27) begin
                  r_cnt   <= 5'd31;
                  r_state <= S_DECRYPT;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end

            S_DECRYPT: begin
               r_x  <= w_x_nxt;
               r_y  <= w_y_nxt;
               r_w3 <= r_w2;
               r_w2 <= r_w1;
               r_w1 <= r_w0;
               r_w0 <= (r_cnt < 5'd4) ? 16'd0 : w_inv_k;
               if (r_cnt == 5'd0) begin
                  r_pt    <= {w_x_nxt, w_y_nxt};
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 5'd1;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.plaintext = r_pt;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_simon_decrypt_iter.sv
// Bench for simon_decrypt_iter: known answers, handshake timing, reset, and a loopback
// against a Simon 32/64 encryption model built from a full expanded key array.
module tb_simon_decrypt_iter;

   localparam logic [63:0] KAT_KEY = 64'h1918111009080100;
   localparam logic [31:0] KAT_CT  = 32'hC69BE9BB;
   localparam logic [31:0] KAT_PT  = 32'h65656877;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   simon_decrypt_iter_if bus();

   simon_decrypt_iter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   string z0_str = "11111010001001010110000111001101111101000100101011000011100110";

   function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
      return (v << n) | (v >> (16 - n));
   endfunction

   function automatic logic [31:0] model_enc(input logic [63:0] key, input logic [31:0] pt);
      logic [15:0] k [32];
      logic [15:0] x, y, t, tmp;
      for (int j = 0; j < 4; j++) k[j] = key[16*j +: 16];
      for (int i = 0; i < 28; i++) begin
         tmp    = rotl(k[i+3], 13) ^ k[i+1];
         k[i+4] = ~k[i] ^ tmp ^ rotl(tmp, 15) ^ 16'd3 ^ ((z0_str[i] == "1") ? 16'd1 : 16'd0);
      end
      x = pt[31:16];
      y = pt[15:0];
      for (int r = 0; r < 32; r++) begin
         t = x;
         x = y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ k[r];
         y = t;
      end
      return {x, y};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulses start for one edge (E0) and waits up to 100 cycles for done.
   // lat is the number of edges after E0 at which done is first seen.
   task automatic run_op(input logic [63:0] key, input logic [31:0] ct, input bit scramble,
                         input int busy_start_at, output logic [31:0] pt, output int lat,
                         output int busy_cnt, output bit overlap);
      pt       = 'x;
      lat      = -1;
      busy_cnt = 0;
      overlap  = 1'b0;
      bus.start      = 1'b1;
      bus.keytext    = key;
      bus.ciphertext = ct;
      tick();
      for (int n = 1; n <= 100; n++) begin
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.busy === 1'b1 && bus.done === 1'b1) overlap = 1'b1;
         if (scramble) begin
            bus.keytext    = {$urandom, $urandom};
            bus.ciphertext = $urandom;
         end
         if (n == busy_start_at) begin
            bus.start      = 1'b1;
            bus.ciphertext = 32'hFFFFFFFF;
         end else begin
            bus.start = 1'b0;
         end
         tick();
         if (bus.done === 1'b1) begin
            lat = n;
            pt  = bus.plaintext;
            if (bus.busy === 1'b1) overlap = 1'b1;
            break;
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.keytext    = 64'd0;
      bus.ciphertext = 32'd0;
      #12;
      n_tests++;
      if (bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
      end
      n_tests++;
      if (bus.done !== 1'b0) begin
         n_fail++; $display("FAIL reset_done: got %b want 0", bus.done);
      end
      n_tests++;
      if (bus.plaintext !== 32'd0) begin
         n_fail++; $display("FAIL reset_plaintext: got %h want 0", bus.plaintext);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_kat();
      logic [31:0] pt; int lat, bc; bit ov;
      run_op(KAT_KEY, KAT_CT, 1'b0, -1, pt, lat, bc, ov);
      n_tests++;
      if (pt !== KAT_PT) begin
         n_fail++; $display("FAIL kat_pt: got %h want %h", pt, KAT_PT);
      end
      n_tests++;
      if (lat != 60) begin
         n_fail++; $display("FAIL kat_latency: got %0d want 60", lat);
      end
      n_tests++;
      if (bc != 60) begin
         n_fail++; $display("FAIL kat_busy_cycles: got %0d want 60", bc);
      end
      n_tests++;
      if (ov) begin
         n_fail++; $display("FAIL kat_busy_done_overlap: got 1 want 0");
      end
      tick();
      n_tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL kat_done_single: got done=%b busy=%b want 0 0", bus.done, bus.busy);
      end
   endtask

   task automatic test_start_while_busy();
      logic [31:0] pt; int lat, bc; bit ov; int extra;
      run_op(KAT_KEY, KAT_CT, 1'b0, 10, pt, lat, bc, ov);
      n_tests++;
      if (pt !== KAT_PT || lat != 60) begin
         n_fail++; $display("FAIL busy_start_result: got pt=%h lat=%0d want %h 60", pt, lat, KAT_PT);
      end
      n_tests++;
      if (bc != 60) begin
         n_fail++; $display("FAIL busy_start_busy_cycles: got %0d want 60", bc);
      end
      extra = 0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (bus.busy === 1'b1 || bus.done === 1'b1) extra++;
      end
      n_tests++;
      if (extra != 0) begin
         n_fail++; $display("FAIL busy_start_no_queued_op: got %0d active cycles want 0", extra);
      end
   endtask

   task automatic test_streaming();
      int dones, prev, bad_gap, bad_pt;
      dones = 0; prev = 0; bad_gap = 0; bad_pt = 0;
      bus.keytext    = KAT_KEY;
      bus.ciphertext = KAT_CT;
      bus.start      = 1'b1;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (bus.done === 1'b1) begin
            dones++;
            if (i - prev != 61) bad_gap++;
            if (bus.plaintext !== KAT_PT) bad_pt++;
            prev = i;
         end
      end
      bus.start = 1'b0;
      n_tests++;
      if (dones != 3) begin
         n_fail++; $display("FAIL stream_done_count: got %0d want 3", dones);
      end
      n_tests++;
      if (bad_gap != 0) begin
         n_fail++; $display("FAIL stream_period: got %0d bad gaps want 0", bad_gap);
      end
      n_tests++;
      if (bad_pt != 0) begin
         n_fail++; $display("FAIL stream_plaintext: got %0d bad results want 0", bad_pt);
      end
      begin
         int w;
         w = 0;
         while (bus.busy === 1'b1 && w < 100) begin
            tick(); w++;
         end
         n_tests++;
         if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL stream_drain: got busy=%b want 0", bus.busy);
         end
      end
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      logic [31:0] pt; int lat, bc; bit ov;
      bus.keytext    = KAT_KEY;
      bus.ciphertext = KAT_CT;
      bus.start      = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 34; i++) tick();
      #4;
      rst = 1'b1;
      #1;
      n_tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_ctrl: got busy=%b done=%b want 0 0", bus.busy, bus.done);
      end
      n_tests++;
      if (bus.plaintext !== 32'd0) begin
         n_fail++; $display("FAIL rst_mid_plaintext: got %h want 0", bus.plaintext);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_quiet: got busy=%b done=%b want 0 0", bus.busy, bus.done);
         end
      end
      run_op(KAT_KEY, KAT_CT, 1'b0, -1, pt, lat, bc, ov);
      n_tests++;
      if (pt !== KAT_PT || lat != 60) begin
         n_fail++; $display("FAIL rst_mid_rerun: got pt=%h lat=%0d want %h 60", pt, lat, KAT_PT);
      end
      tick();
   endtask

   task automatic test_hold_off();
      logic [31:0] pt; int lat, bc; bit ov;
      run_op(KAT_KEY, KAT_CT, 1'b1, -1, pt, lat, bc, ov);
      n_tests++;
      if (pt !== KAT_PT || lat != 60) begin
         n_fail++; $display("FAIL hold_off: got pt=%h lat=%0d want %h 60", pt, lat, KAT_PT);
      end
      tick();
   endtask

   task automatic test_loopback();
      logic [63:0] key; logic [31:0] orig, ct, pt; int lat, bc; bit ov;
      for (int i = 0; i < 1000; i++) begin
         if (i == 0)      key = 64'h0000000000000000;
         else if (i == 1) key = 64'hFFFFFFFFFFFFFFFF;
         else             key = {$urandom, $urandom};
         orig = $urandom;
         ct   = model_enc(key, orig);
         run_op(key, ct, 1'b0, -1, pt, lat, bc, ov);
         n_tests++;
         if (pt !== orig || lat != 60 || ov) begin
            n_fail++;
            $display("FAIL loopback[%0d]: key=%h got pt=%h lat=%0d ov=%b want pt=%h lat=60 ov=0",
                     i, key, pt, lat, ov, orig);
         end
      end
   endtask

   initial begin
      test_reset();
      test_kat();
      test_start_while_busy();
      test_streaming();
      test_reset_mid();
      test_hold_off();
      test_loopback();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
